mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the 8-state CPU controller's mem_rd/mem_wr strobe interface.
- Holds program and data words for the CPU.
- Returns read data with one-cycle registered latency and commits writes exactly once per write strobe.
- Flags illegal strobe combinations and keeps access counters for the bench.
- Sits between the CPU datapath address/data buses and the controller strobes; replaces the combinational memory model.

Parameters:
- AWIDTH, 5, address width; DEPTH = 2**AWIDTH words.
- DWIDTH, 8, data word width.
- CNT_W, 16, width of rd_count/wr_count.
- WP_LIMIT, 8, number of write-protected low addresses (0..WP_LIMIT-1); used only with MEM_WRPROT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_  in  1  asynchronous, active-low reset.
- addr  in  AWIDTH  word address from CPU address mux.
- mem_rd  in  1  read strobe from controller, level, may stay high several cycles.
- mem_wr  in  1  write strobe from controller, level.
- data_in  in  DWIDTH  write data (accumulator).
- data_out  out  DWIDTH  registered read data.
- data_valid  out  1  data_out corresponds to current addr under an active read.
- bus_err  out  1  sticky: mem_rd and mem_wr sampled high together.
- wp_viol  out  1  one-cycle pulse on a blocked write (MEM_WRPROT_EN only, else 0).
- rd_count  out  CNT_W  number of read transactions, saturating.
- wr_count  out  CNT_W  number of committed writes, saturating.
- tl_en  in  1  bench preload enable.
- tl_addr  in  AWIDTH  preload address.
- tl_data  in  DWIDTH  preload data.

Behaviour:
- Reset (async, rst_ low):
  - State M_IDLE; data_out=0, data_valid=0, bus_err=0, wp_viol=0, rd_count=0, wr_count=0.
  - Array contents are NOT cleared.
- FSM states: M_IDLE, M_READ, M_WRITE, M_ERR.
- M_IDLE:
  - mem_rd=1, mem_wr=0 -> M_READ; latch addr; rd_count+1.
  - mem_wr=1, mem_rd=0 -> M_WRITE; commit data_in to mem[addr] at this edge; wr_count+1.
  - Both high -> M_ERR; bus_err=1; no access performed.
- M_READ:
  - data_out=mem[latched addr] and data_valid=1 in the first cycle after entry, i.e. one-cycle latency from mem_rd rise.
  - Stays in M_READ while mem_rd=1; data_out is refreshed every cycle.
  - If addr changes while mem_rd=1: data_valid=0 for one cycle, new word presented next cycle; rd_count not incremented.
  - mem_rd=0 -> M_IDLE; data_valid=0; data_out holds its last value.
  - mem_wr rising while in M_READ -> M_ERR.
- M_WRITE:
  - Holds while mem_wr=1 with no further commits (one write per strobe; later data_in changes ignored).
  - mem_wr=0 -> M_IDLE.
  - mem_rd=1 while in M_WRITE -> M_ERR.
- M_ERR:
  - Absorbing until reset; bus_err=1; data_valid=0; no reads or writes.
  - tl port remains functional.
- Read-after-write: a read strobe beginning the cycle after a write to the same address returns the new data.
- Test-load port:
  - tl_en=1 writes tl_data to mem[tl_addr] at the edge.
  - Has priority over a bus write to the same cycle/address; that bus write is dropped but still counted.
  - Never affects counters or FSM state.
- Counters saturate at 2**CNT_W-1; no wrap.
- addr is always within DEPTH (full decode); no out-of-range case exists.

Optional Feature:
- Macro MEM_WRPROT_EN.
- Defined:
  - Bus writes with addr < WP_LIMIT are blocked; the array is unchanged, wp_viol pulses high for one cycle, wr_count is not incremented, and the FSM still enters M_WRITE.
  - tl port ignores protection.
- Undefined: no protection; wp_viol tied 0; WP_LIMIT unused.

Decomposition:
- Shared typedefs package: mem_state_t enum (M_IDLE, M_READ, M_WRITE, M_ERR) and default width constants (AWIDTH=5, DWIDTH=8).
- Sub-module mem_array:
  - DEPTH x DWIDTH storage.
  - One write port with tl-priority mux.
  - One synchronous read port.
- FSM, counters, and error/protection logic live in mem_responder.

Test Plan:
1. Reset: assert rst_ low mid-simulation -> data_out=0, data_valid=0, bus_err=0, rd_count=0, wr_count=0 immediately, without waiting for a clock edge.
2. Read: tl preload mem[5]=8'hA7; addr=5, mem_rd high 3 cycles -> data_valid=1 from cycle 2, data_out=8'hA7, rd_count=1 after strobe drops.
3. Write:
   - addr=5'h1F, data_in=8'h3C, mem_wr 1 cycle, then read 5'h1F -> data_out=8'h3C, wr_count=1.
   - Then hold mem_wr 3 cycles at 5'h10 with data 8'h11, 8'h22, 8'h33 -> mem[5'h10]=8'h11, wr_count=2.
4. Error: mem_rd=mem_wr=1 at addr=2, preloaded mem[2]=8'h55 -> bus_err=1 sticky, mem[2] remains 8'h55, later strobes ignored until rst_.
5. Address change mid-read: mem_rd held, addr 3->4 (mem[3]=8'h01, mem[4]=8'h02) -> data_valid dips one cycle, then data_out=8'h02, rd_count=1.
6. MEM_WRPROT_EN, WP_LIMIT=8:
   - Write 8'hFF to addr 3 -> wp_viol one-cycle pulse, mem[3] unchanged, wr_count unchanged.
   - Write to addr 8 -> committed, wr_count+1.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared state type and default widths for the mem_responder slice.
package mem_responder_pkg;

    localparam int          AWIDTH_DEF   = 5;
    localparam int          DWIDTH_DEF   = 8;
    localparam int          CNT_W_DEF    = 16;
    localparam int unsigned WP_LIMIT_DEF = 8;

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_READ  = 2'd1,
        M_WRITE = 2'd2,
        M_ERR   = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DWIDTH word store: one write port where the test-load port beats the bus,
// and one registered read port whose output holds while rd_en_i is low.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              we_i,
    input  logic [AWIDTH-1:0] addr_i,
    input  logic [DWIDTH-1:0] wdata_i,
    input  logic              tl_en_i,
    input  logic [AWIDTH-1:0] tl_addr_i,
    input  logic [DWIDTH-1:0] tl_data_i,
    input  logic              rd_en_i,
    input  logic [AWIDTH-1:0] raddr_i,
    output logic [DWIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rd_data_q;
    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;

    always_comb begin
        wr_en   = tl_en_i | we_i;
        wr_addr = tl_en_i ? tl_addr_i : addr_i;
        wr_data = tl_en_i ? tl_data_i : wdata_i;
    end

    // Storage is intentionally not reset; contents survive rst_.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[raddr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the CPU controller strobes: registered reads, one commit per write strobe,
// sticky bus-error capture, saturating counters. Define MEM_WRPROT_EN to block bus writes below WP_LIMIT.
//
// state   | meaning
// M_IDLE  | no strobe active, waiting for mem_rd or mem_wr
// M_READ  | read strobe active, data_out refreshed from latched address
// M_WRITE | write already committed, waiting for mem_wr to drop
// M_ERR   | illegal strobe combination seen, absorbing until rst_
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          AWIDTH   = AWIDTH_DEF,
    parameter int          DWIDTH   = DWIDTH_DEF,
    parameter int          CNT_W    = CNT_W_DEF,
    parameter int unsigned WP_LIMIT = WP_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [AWIDTH-1:0] addr,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              data_valid,
    output logic              bus_err,
    output logic              wp_viol,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count,
    input  logic              tl_en,
    input  logic [AWIDTH-1:0] tl_addr,
    input  logic [DWIDTH-1:0] tl_data
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef MEM_WRPROT_EN
    localparam logic WP_ON = 1'b1;
`else
    localparam logic WP_ON = 1'b0;
`endif

    mem_state_t        state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              bus_err_q, bus_err_d;
    logic              wp_viol_q, wp_viol_d;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;
    logic [CNT_W-1:0]  wr_count_q, wr_count_d;
    logic              rd_inc, wr_inc;
    logic              bus_we, rd_en;
    logic              wp_hit;

    assign wp_hit = WP_ON && (32'(addr) < WP_LIMIT);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        valid_d   = 1'b0;
        bus_err_d = bus_err_q;
        wp_viol_d = 1'b0;
        rd_inc    = 1'b0;
        wr_inc    = 1'b0;
        bus_we    = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            M_IDLE: begin
                if (mem_rd && mem_wr) begin
                    state_d   = M_ERR;
                    bus_err_d = 1'b1;
                end else if (mem_rd) begin
                    state_d = M_READ;
                    addr_d  = addr;
                    rd_en   = 1'b1;
                    valid_d = 1'b1;
                    rd_inc  = 1'b1;
                end else if (mem_wr) begin
                    state_d = M_WRITE;
                    if (wp_hit) begin
                        wp_viol_d = 1'b1;
                    end else begin
                        bus_we = 1'b1;
                        wr_inc = 1'b1;
                    end
                end
            end
            M_READ: begin
                if (mem_wr) begin
                    state_d   = M_ERR;
                    bus_err_d = 1'b1;
                end else if (!mem_rd) begin
                    state_d = M_IDLE;
                end else if (addr != addr_q) begin
                    // Address moved under a held strobe: drop valid for a cycle, re-fetch next.
                    addr_d = addr;
                end else begin
                    rd_en   = 1'b1;
                    valid_d = 1'b1;
                end
            end
            M_WRITE: begin
                if (mem_rd) begin
                    state_d   = M_ERR;
                    bus_err_d = 1'b1;
                end else if (!mem_wr) begin
                    state_d = M_IDLE;
                end
            end
            M_ERR: begin
                bus_err_d = 1'b1;
            end
            default: begin
                state_d   = M_ERR;
                bus_err_d = 1'b1;
            end
        endcase
    end

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (rd_inc && (rd_count_q != CNT_MAX)) begin
            rd_count_d = rd_count_q + CNT_W'(1);
        end
        if (wr_inc && (wr_count_q != CNT_MAX)) begin
            wr_count_d = wr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= M_IDLE;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            bus_err_q  <= 1'b0;
            wp_viol_q  <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            bus_err_q  <= bus_err_d;
            wp_viol_q  <= wp_viol_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    mem_array #(
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_mem_array (
        .clk       (clk),
        .rst_      (rst_),
        .we_i      (bus_we),
        .addr_i    (addr),
        .wdata_i   (data_in),
        .tl_en_i   (tl_en),
        .tl_addr_i (tl_addr),
        .tl_data_i (tl_data),
        .rd_en_i   (rd_en),
        .raddr_i   (addr),
        .rd_data_o (data_out)
    );

    assign data_valid = valid_q;
    assign bus_err    = bus_err_q;
    assign wp_viol    = wp_viol_q;
    assign rd_count   = rd_count_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand-written error/reset/saturation sequences,
// and randomized strobe traffic checked against a behavioural model. Honors MEM_WRPROT_EN.
module tb_mem_responder;

    localparam int TB_CNT_W = 4;
    localparam int CMAX     = (1 << TB_CNT_W) - 1;
`ifdef MEM_WRPROT_EN
    localparam bit TB_WP = 1'b1;
`else
    localparam bit TB_WP = 1'b0;
`endif

    logic                clk, rst_;
    logic [4:0]          addr, tl_addr;
    logic                mem_rd, mem_wr, tl_en;
    logic [7:0]          data_in, tl_data, data_out;
    logic                data_valid, bus_err, wp_viol;
    logic [TB_CNT_W-1:0] rd_count, wr_count;

    int checks = 0;
    int errors = 0;

    mem_responder #(
        .AWIDTH   (5),
        .DWIDTH   (8),
        .CNT_W    (TB_CNT_W),
        .WP_LIMIT (8)
    ) dut (
        .clk        (clk),
        .rst_       (rst_),
        .addr       (addr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .bus_err    (bus_err),
        .wp_viol    (wp_viol),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .tl_en      (tl_en),
        .tl_addr    (tl_addr),
        .tl_data    (tl_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rd, wr;
        logic [4:0] a;
        logic [7:0] d;
        logic       t;
        logic [4:0] ta;
        logic [7:0] td;
        logic       ev;
        logic [7:0] ed;
        logic [3:0] erc, ewc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rd, logic wr, logic [4:0] a, logic [7:0] d, logic t,
                                logic [4:0] ta, logic [7:0] td, logic ev, logic [7:0] ed,
                                logic [3:0] erc, logic [3:0] ewc);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.t = t; v.ta = ta; v.td = td;
        v.ev = ev; v.ed = ed; v.erc = erc; v.ewc = ewc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: strobe protocol as flags, memory as a plain array.
    bit         m_reading, m_writing, m_err, m_valid, m_wp;
    logic [4:0] m_raddr;
    logic [7:0] m_dout;
    logic [7:0] m_mem [32];
    int         m_rc, m_wc;

    function automatic int sat(int c);
        return (c < CMAX) ? c + 1 : c;
    endfunction

    task automatic model_reset();
        m_reading = 0; m_writing = 0; m_err = 0; m_valid = 0; m_wp = 0;
        m_raddr = '0; m_dout = '0; m_rc = 0; m_wc = 0;
    endtask

    task automatic model_edge();
        bit bus_write;
        bus_write = 0;
        m_wp = 0;
        if (m_err) begin
            m_valid = 0;
        end else if (m_reading) begin
            if (mem_wr) begin
                m_err = 1; m_reading = 0; m_valid = 0;
            end else if (!mem_rd) begin
                m_reading = 0; m_valid = 0;
            end else if (addr != m_raddr) begin
                m_raddr = addr; m_valid = 0;
            end else begin
                m_dout = m_mem[addr]; m_valid = 1;
            end
        end else if (m_writing) begin
            if (mem_rd) begin
                m_err = 1; m_writing = 0;
            end else if (!mem_wr) begin
                m_writing = 0;
            end
        end else begin
            if (mem_rd && mem_wr) begin
                m_err = 1;
            end else if (mem_rd) begin
                m_reading = 1; m_raddr = addr; m_dout = m_mem[addr]; m_valid = 1;
                m_rc = sat(m_rc);
            end else if (mem_wr) begin
                m_writing = 1;
                if (TB_WP && addr < 5'd8) m_wp = 1;
                else begin
                    bus_write = 1;
                    m_wc = sat(m_wc);
                end
            end
        end
        if (tl_en) m_mem[tl_addr] = tl_data;
        else if (bus_write) m_mem[addr] = data_in;
    endtask

    task automatic step_model();
        model_edge();
        cyc();
        chk("rnd_dout", data_out, m_dout);
        chk("rnd_valid", data_valid, m_valid);
        chk("rnd_err", bus_err, m_err);
        chk("rnd_wp", wp_viol, m_wp);
        chk("rnd_rc", rd_count, m_rc);
        chk("rnd_wc", wr_count, m_wc);
    endtask

    // Called at posedge+1; checks the asynchronous reset values before any edge.
    task automatic do_reset();
        mem_rd = 0; mem_wr = 0; tl_en = 0;
        #2;
        rst_ = 1'b0;
        #1;
        model_reset();
        chk("rst_dout", data_out, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_err", bus_err, 0);
        chk("rst_wp", wp_viol, 0);
        chk("rst_rc", rd_count, 0);
        chk("rst_wc", wr_count, 0);
        cyc();
        rst_ = 1'b1;
    endtask

    task automatic rd_word(input logic [4:0] a, input logic [7:0] exp, input string nm);
        mem_rd = 1; addr = a;
        cyc();
        chk({nm, "_valid"}, data_valid, 1);
        chk({nm, "_dout"}, data_out, exp);
        mem_rd = 0;
        cyc();
    endtask

    initial begin
        int k;
        rst_ = 1'b0; mem_rd = 0; mem_wr = 0; tl_en = 0;
        addr = '0; data_in = '0; tl_addr = '0; tl_data = '0;
        #2;
        chk("init_dout", data_out, 0);
        chk("init_valid", data_valid, 0);
        chk("init_err", bus_err, 0);
        chk("init_rc", rd_count, 0);
        chk("init_wc", wr_count, 0);
        cyc();
        rst_ = 1'b1;

        //               rd wr addr   din    tl ta     td     ev ed     rc wc
        tbl.push_back(mk(0, 0, 5'h00, 8'h00, 1, 5'h05, 8'hA7, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 5'h00, 8'h00, 1, 5'h03, 8'h01, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 5'h00, 8'h00, 1, 5'h04, 8'h02, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 5'h00, 8'h00, 1, 5'h02, 8'h55, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 5'h05, 8'h00, 0, 5'h00, 8'h00, 1, 8'hA7, 1, 0));
        tbl.push_back(mk(1, 0, 5'h05, 8'h00, 0, 5'h00, 8'h00, 1, 8'hA7, 1, 0));
        tbl.push_back(mk(1, 0, 5'h05, 8'h00, 0, 5'h00, 8'h00, 1, 8'hA7, 1, 0));
        tbl.push_back(mk(0, 0, 5'h05, 8'h00, 0, 5'h00, 8'h00, 0, 8'hA7, 1, 0));
        tbl.push_back(mk(0, 1, 5'h1F, 8'h3C, 0, 5'h00, 8'h00, 0, 8'hA7, 1, 1));
        tbl.push_back(mk(0, 0, 5'h1F, 8'h00, 0, 5'h00, 8'h00, 0, 8'hA7, 1, 1));
        tbl.push_back(mk(1, 0, 5'h1F, 8'h00, 0, 5'h00, 8'h00, 1, 8'h3C, 2, 1));
        tbl.push_back(mk(0, 0, 5'h1F, 8'h00, 0, 5'h00, 8'h00, 0, 8'h3C, 2, 1));
        tbl.push_back(mk(0, 1, 5'h10, 8'h11, 0, 5'h00, 8'h00, 0, 8'h3C, 2, 2));
        tbl.push_back(mk(0, 1, 5'h10, 8'h22, 0, 5'h00, 8'h00, 0, 8'h3C, 2, 2));
        tbl.push_back(mk(0, 1, 5'h10, 8'h33, 0, 5'h00, 8'h00, 0, 8'h3C, 2, 2));
        tbl.push_back(mk(0, 0, 5'h10, 8'h00, 0, 5'h00, 8'h00, 0, 8'h3C, 2, 2));
        tbl.push_back(mk(1, 0, 5'h10, 8'h00, 0, 5'h00, 8'h00, 1, 8'h11, 3, 2));
        tbl.push_back(mk(0, 0, 5'h10, 8'h00, 0, 5'h00, 8'h00, 0, 8'h11, 3, 2));
        tbl.push_back(mk(1, 0, 5'h03, 8'h00, 0, 5'h00, 8'h00, 1, 8'h01, 4, 2));
        tbl.push_back(mk(1, 0, 5'h04, 8'h00, 0, 5'h00, 8'h00, 0, 8'h01, 4, 2));
        tbl.push_back(mk(1, 0, 5'h04, 8'h00, 0, 5'h00, 8'h00, 1, 8'h02, 4, 2));
        tbl.push_back(mk(0, 0, 5'h04, 8'h00, 0, 5'h00, 8'h00, 0, 8'h02, 4, 2));
        tbl.push_back(mk(0, 1, 5'h0C, 8'h99, 1, 5'h0C, 8'h77, 0, 8'h02, 4, 3));
        tbl.push_back(mk(0, 0, 5'h0C, 8'h00, 0, 5'h00, 8'h00, 0, 8'h02, 4, 3));
        tbl.push_back(mk(1, 0, 5'h0C, 8'h00, 0, 5'h00, 8'h00, 1, 8'h77, 5, 3));
        tbl.push_back(mk(0, 0, 5'h0C, 8'h00, 0, 5'h00, 8'h00, 0, 8'h77, 5, 3));

        foreach (tbl[i]) begin
            mem_rd = tbl[i].rd; mem_wr = tbl[i].wr; addr = tbl[i].a; data_in = tbl[i].d;
            tl_en = tbl[i].t; tl_addr = tbl[i].ta; tl_data = tbl[i].td;
            cyc();
            chk($sformatf("vec%0d_valid", i), data_valid, tbl[i].ev);
            chk($sformatf("vec%0d_dout", i), data_out, tbl[i].ed);
            chk($sformatf("vec%0d_rc", i), rd_count, tbl[i].erc);
            chk($sformatf("vec%0d_wc", i), wr_count, tbl[i].ewc);
            chk($sformatf("vec%0d_err", i), bus_err, 0);
            chk($sformatf("vec%0d_wp", i), wp_viol, 0);
        end
        tl_en = 0; mem_rd = 0; mem_wr = 0;

        // Both strobes together: sticky error, nothing accessed, later strobes ignored.
        mem_rd = 1; mem_wr = 1; addr = 5'h02; data_in = 8'hEE;
        cyc();
        chk("err_set", bus_err, 1);
        chk("err_valid", data_valid, 0);
        mem_rd = 0; mem_wr = 0;
        cyc();
        chk("err_sticky", bus_err, 1);
        mem_rd = 1;
        cyc(); cyc();
        chk("err_rd_valid", data_valid, 0);
        chk("err_rd_rc", rd_count, 5);
        mem_rd = 0; mem_wr = 1; addr = 5'h0C; data_in = 8'hAA;
        cyc();
        mem_wr = 0;
        chk("err_wr_wc", wr_count, 3);
        tl_en = 1; tl_addr = 5'h0D; tl_data = 8'h5A;
        cyc();
        tl_en = 0;
        chk("err_dout_hold", data_out, 8'h77);

        do_reset();
        rd_word(5'h02, 8'h55, "post_err_m2");
        rd_word(5'h0C, 8'h77, "post_err_mC");
        rd_word(5'h0D, 8'h5A, "post_err_mD");
        chk("post_err_rc", rd_count, 3);

        // Write strobe arriving during a read.
        mem_rd = 1; addr = 5'h0D;
        cyc();
        mem_wr = 1;
        cyc();
        chk("rd2err_err", bus_err, 1);
        chk("rd2err_valid", data_valid, 0);
        do_reset();

        // Read strobe arriving during a write.
        mem_wr = 1; addr = 5'h0E; data_in = 8'h12;
        cyc();
        mem_rd = 1;
        cyc();
        chk("wr2err_err", bus_err, 1);
        chk("wr2err_wc", wr_count, 1);
        do_reset();
        rd_word(5'h0E, 8'h12, "wr2err_m");

        // Counter saturation.
        for (int i = 0; i < 18; i++) begin
            mem_rd = 1; addr = 5'h0D;
            cyc();
            mem_rd = 0;
            cyc();
        end
        chk("sat_rc", rd_count, CMAX);
        chk("sat_dout", data_out, 8'h5A);
        do_reset();

`ifdef MEM_WRPROT_EN
        mem_wr = 1; addr = 5'h03; data_in = 8'hFF;
        cyc();
        chk("wp_pulse", wp_viol, 1);
        chk("wp_wc", wr_count, 0);
        mem_wr = 0;
        cyc();
        chk("wp_pulse_end", wp_viol, 0);
        rd_word(5'h03, 8'h01, "wp_m3");
        mem_wr = 1; addr = 5'h08; data_in = 8'h4B;
        cyc();
        chk("wp8_pulse", wp_viol, 0);
        chk("wp8_wc", wr_count, 1);
        mem_wr = 0;
        cyc();
        rd_word(5'h08, 8'h4B, "wp_m8");
`else
        mem_wr = 1; addr = 5'h03; data_in = 8'hFF;
        cyc();
        chk("nowp_pulse", wp_viol, 0);
        chk("nowp_wc", wr_count, 1);
        mem_wr = 0;
        cyc();
        rd_word(5'h03, 8'hFF, "nowp_m3");
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int a = 0; a < 32; a++) begin
            tl_en = 1; tl_addr = 5'(a); tl_data = 8'($urandom);
            step_model();
        end
        tl_en = 0;
        for (int s = 0; s < 15; s++) begin
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 99) < 30) begin
                    if ((mem_rd || mem_wr) && $urandom_range(0, 9) != 0) begin
                        mem_rd = 0; mem_wr = 0;
                    end else begin
                        k = $urandom_range(0, 99);
                        mem_rd = (k >= 40 && k < 75) || (k >= 97);
                        mem_wr = (k >= 75);
                    end
                end
                if ($urandom_range(0, 99) < 20) addr = 5'($urandom_range(0, 31));
                data_in = 8'($urandom);
                tl_en   = ($urandom_range(0, 99) < 10);
                tl_addr = 5'($urandom_range(0, 31));
                tl_data = 8'($urandom);
                step_model();
            end
            do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
